gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 171 +++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Drives the two-input basic-gates block through all four {A,B} input
//   combinations. Each vector is held for SETTLE cycles, and then the seven
//   gate outputs are sampled and compared against the golden truth table.
//   The block reports the captured table, a per-vector fail mask and a pass
//   flag, and keeps a count of passing sweeps.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a sweep (only honoured in IDLE)
//   and_i .. exnor_i    gate block outputs returned to the checker
//   a_o, b_o            gate block inputs A and B (= vector index bits 1, 0)
//   busy                high while vectors are being applied
//   done                one-cycle pulse when a sweep completes
//   pass                last sweep matched on all four vectors
//   fail_mask[3:0]      bit k set if vector k = {A,B} mismatched
//   tt[27:0]            captured table, tt[7k+6:7k] = {and,or,nota,nand,nor,exor,exnor}
//   sweeps_ok[7:0]      number of passing sweeps, saturating at 255
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        and_i,
  input  logic        or_i,
  input  logic        nota_i,
  input  logic        nand_i,
  input  logic        nor_i,
  input  logic        exor_i,
  input  logic        exnor_i,
  output logic        a_o,
  output logic        b_o,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_mask,
  output logic [27:0] tt,
  output logic [7:0]  sweeps_ok
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [27:0] tt_q, tt_d;
  logic [3:0]  fail_q, fail_d;
  logic        pass_q, pass_d;
  logic [7:0]  sweeps_q, sweeps_d;

  logic [6:0]  word;
  logic [6:0]  golden;
  logic        mismatch;
  logic [3:0]  mask_upd;

  assign word = {and_i, or_i, nota_i, nand_i, nor_i, exor_i, exnor_i};

  always_comb begin
    golden = 7'h1D;
    case (idx_q)
      2'd0:    golden = 7'h1D;
      2'd1:    golden = 7'h3A;
      2'd2:    golden = 7'h2A;
      default: golden = 7'h61;
    endcase
  end

  // Case-inequality so that an X or Z on any gate output is a mismatch
  // rather than silently passing.
  assign mismatch = (word !== golden);

  always_comb begin
    mask_upd = fail_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (idx_q == 2'(k)) mask_upd[k] = mismatch;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tt_d     = tt_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    sweeps_d = sweeps_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (idx_q == 2'(k)) tt_d[7*k +: 7] = word;
          end
          fail_d = mask_upd;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            cnt_d = '0;
          end else begin
            // The pass verdict must include the vector-3 result captured at
            // this same edge, so it is taken from the updated mask.
            state_d = S_DONE;
            pass_d  = (mask_upd == 4'd0);
            if ((mask_upd == 4'd0) && (sweeps_q != 8'hFF)) begin
              sweeps_d = sweeps_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      tt_q     <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
      sweeps_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tt_q     <= tt_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      sweeps_q <= sweeps_d;
    end
  end

  assign a_o       = idx_q[1];
  assign b_o       = idx_q[0];
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign tt        = tt_q;
  assign sweeps_ok = sweeps_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst;
  logic start2, start1;
  logic force_and;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [27:0] TT_GOOD = 28'hC2A9D1D;
  localparam logic [27:0] TT_AND1 = 28'hC3ABD5D;

  always #5 clk = ~clk;

  // DUT with SETTLE=2 and its gate block (with an injectable AND fault)
  logic a2, b2, busy2, done2, pass2;
  logic [3:0]  fm2;
  logic [27:0] tt2;
  logic [7:0]  sw2;
  logic g2_and, g2_or, g2_nota, g2_nand, g2_nor, g2_exor, g2_exnor;

  assign g2_and   = force_and ? 1'b1 : (a2 & b2);
  assign g2_or    = a2 | b2;
  assign g2_nota  = ~a2;
  assign g2_nand  = ~(a2 & b2);
  assign g2_nor   = ~(a2 | b2);
  assign g2_exor  = a2 ^ b2;
  assign g2_exnor = ~(a2 ^ b2);

  gate_sweep_checker #(.SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .and_i(g2_and), .or_i(g2_or), .nota_i(g2_nota), .nand_i(g2_nand),
    .nor_i(g2_nor), .exor_i(g2_exor), .exnor_i(g2_exnor),
    .a_o(a2), .b_o(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fm2), .tt(tt2), .sweeps_ok(sw2)
  );

  // DUT with SETTLE=1 and a correct gate block
  logic a1, b1, busy1, done1, pass1;
  logic [3:0]  fm1;
  logic [27:0] tt1;
  logic [7:0]  sw1;

  gate_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .and_i(a1 & b1), .or_i(a1 | b1), .nota_i(~a1), .nand_i(~(a1 & b1)),
    .nor_i(~(a1 | b1)), .exor_i(a1 ^ b1), .exnor_i(~(a1 ^ b1)),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .tt(tt1), .sweeps_ok(sw1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if ({a2, b2} !== 2'b00) begin miscompares++; $display("FAIL reset_ab got %b want 00", {a2, b2}); end
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy2); end
    vectors++; if (done2 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done2); end
    vectors++; if (pass2 !== 1'b0) begin miscompares++; $display("FAIL reset_pass got %b want 0", pass2); end
    vectors++; if (fm2 !== 4'h0) begin miscompares++; $display("FAIL reset_mask got %h want 0", fm2); end
    vectors++; if (tt2 !== 28'h0) begin miscompares++; $display("FAIL reset_tt got %h want 0", tt2); end
    vectors++; if (sw2 !== 8'h0) begin miscompares++; $display("FAIL reset_sweeps got %0d want 0", sw2); end
    vectors++; if ({a1, b1, busy1, done1, pass1} !== 5'b0) begin miscompares++; $display("FAIL reset_dut1 got %b want 00000", {a1, b1, busy1, done1, pass1}); end
    rst = 1'b0;
    tick();
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy2); end
  endtask

  task automatic test_sweep_ok();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      vectors++; if ({a2, b2} !== 2'(c / 2)) begin miscompares++; $display("FAIL sweep_ab c=%0d got %b want %b", c, {a2, b2}, 2'(c / 2)); end
      vectors++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin miscompares++; $display("FAIL sweep_busydone c=%0d got %b%b want 10", c, busy2, done2); end
      tick();
    end
    vectors++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin miscompares++; $display("FAIL sweep_donepulse got busy=%b done=%b want busy=0 done=1", busy2, done2); end
    vectors++; if ({a2, b2} !== 2'b11) begin miscompares++; $display("FAIL sweep_done_ab got %b want 11", {a2, b2}); end
    vectors++; if (tt2 !== TT_GOOD) begin miscompares++; $display("FAIL sweep_tt got %h want %h", tt2, TT_GOOD); end
    vectors++; if (fm2 !== 4'h0) begin miscompares++; $display("FAIL sweep_mask got %b want 0000", fm2); end
    vectors++; if (pass2 !== 1'b1) begin miscompares++; $display("FAIL sweep_pass got %b want 1", pass2); end
    vectors++; if (sw2 !== 8'd1) begin miscompares++; $display("FAIL sweep_count got %0d want 1", sw2); end
    tick();
    vectors++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL sweep_after got busy=%b done=%b want 0 0", busy2, done2); end
    vectors++; if ({a2, b2} !== 2'b00) begin miscompares++; $display("FAIL sweep_after_ab got %b want 00", {a2, b2}); end
    vectors++; if (tt2 !== TT_GOOD || pass2 !== 1'b1) begin miscompares++; $display("FAIL sweep_hold got tt=%h pass=%b want %h 1", tt2, pass2, TT_GOOD); end
  endtask

  task automatic test_and_fault();
    int n;
    force_and = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++; if (n != 8) begin miscompares++; $display("FAIL fault_latency got %0d want 8", n); end
    vectors++; if (fm2 !== 4'b0111) begin miscompares++; $display("FAIL fault_mask got %b want 0111", fm2); end
    vectors++; if (pass2 !== 1'b0) begin miscompares++; $display("FAIL fault_pass got %b want 0", pass2); end
    vectors++; if (sw2 !== 8'd1) begin miscompares++; $display("FAIL fault_count got %0d want 1", sw2); end
    vectors++; if (tt2 !== TT_AND1) begin miscompares++; $display("FAIL fault_tt got %h want %h", tt2, TT_AND1); end
    tick();
    force_and = 1'b0;
  endtask

  task automatic test_start_in_run();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    vectors++; if ({a2, b2} !== 2'b01) begin miscompares++; $display("FAIL run_idx1 got %b want 01", {a2, b2}); end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 3; c < 8; c++) begin
      vectors++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin miscompares++; $display("FAIL run_ignore c=%0d got busy=%b done=%b want 1 0", c, busy2, done2); end
      vectors++; if ({a2, b2} !== 2'(c / 2)) begin miscompares++; $display("FAIL run_ab c=%0d got %b want %b", c, {a2, b2}, 2'(c / 2)); end
      tick();
    end
    vectors++; if (done2 !== 1'b1) begin miscompares++; $display("FAIL run_done got %b want 1", done2); end
    vectors++; if (pass2 !== 1'b1 || tt2 !== TT_GOOD) begin miscompares++; $display("FAIL run_result got pass=%b tt=%h want 1 %h", pass2, tt2, TT_GOOD); end
    vectors++; if (sw2 !== 8'd2) begin miscompares++; $display("FAIL run_count got %0d want 2", sw2); end
    tick();
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL run_no_restart got %b want 0", busy2); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    vectors++; if ({a2, b2} !== 2'b10) begin miscompares++; $display("FAIL mid_idx2 got %b want 10", {a2, b2}); end
    rst = 1'b1;
    start2 = 1'b1;
    tick();
    vectors++; if ({a2, b2, busy2, done2, pass2} !== 5'b0) begin miscompares++; $display("FAIL mid_reset_ctl got %b want 00000", {a2, b2, busy2, done2, pass2}); end
    vectors++; if (tt2 !== 28'h0 || fm2 !== 4'h0 || sw2 !== 8'h0) begin miscompares++; $display("FAIL mid_reset_data got tt=%h mask=%b sweeps=%0d want 0 0 0", tt2, fm2, sw2); end
    tick();
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rst_wins got busy=%b want 0", busy2); end
    rst = 1'b0;
    start2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin miscompares++; $display("FAIL mid_quiet c=%0d got busy=%b done=%b want 0 0", c, busy2, done2); end
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++; if (n != 8) begin miscompares++; $display("FAIL mid_latency got %0d want 8", n); end
    vectors++; if (pass2 !== 1'b1 || fm2 !== 4'h0) begin miscompares++; $display("FAIL mid_pass got pass=%b mask=%b want 1 0000", pass2, fm2); end
    vectors++; if (tt2 !== TT_GOOD) begin miscompares++; $display("FAIL mid_tt got %h want %h", tt2, TT_GOOD); end
    vectors++; if (sw2 !== 8'd1) begin miscompares++; $display("FAIL mid_count got %0d want 1", sw2); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses, cyc, last, exp_sw;
    start1 = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      vectors++; if ({a1, b1} !== 2'(c)) begin miscompares++; $display("FAIL s1_ab c=%0d got %b want %b", c, {a1, b1}, 2'(c)); end
      vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL s1_early_done c=%0d got %b want 0", c, done1); end
      tick();
    end
    vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL s1_first_done got %b want 1", done1); end
    vectors++; if (sw1 !== 8'd1) begin miscompares++; $display("FAIL s1_first_count got %0d want 1", sw1); end
    pulses = 1;
    cyc = 0;
    last = 0;
    while (pulses < 300 && cyc < 2000) begin
      tick();
      cyc++;
      if (done1 === 1'b1) begin
        pulses++;
        exp_sw = (pulses < 255) ? pulses : 255;
        vectors++; if (cyc - last != 6) begin miscompares++; $display("FAIL b2b_period pulse=%0d got %0d want 6", pulses, cyc - last); end
        vectors++; if (sw1 !== 8'(exp_sw)) begin miscompares++; $display("FAIL b2b_count pulse=%0d got %0d want %0d", pulses, sw1, exp_sw); end
        last = cyc;
      end
    end
    vectors++; if (pulses != 300) begin miscompares++; $display("FAIL b2b_pulses got %0d want 300", pulses); end
    vectors++; if (sw1 !== 8'd255) begin miscompares++; $display("FAIL b2b_saturate got %0d want 255", sw1); end
    vectors++; if (pass1 !== 1'b1 || tt1 !== TT_GOOD || fm1 !== 4'h0) begin miscompares++; $display("FAIL b2b_result got pass=%b tt=%h mask=%b want 1 %h 0000", pass1, tt1, fm1, TT_GOOD); end
    start1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start2 = 1'b0;
    start1 = 1'b0;
    force_and = 1'b0;
    test_reset();
    test_sweep_ok();
    test_and_fault();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
